ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter that shares one multi-cycle data RAM port (cs/we/addr/din in, dout/ack back) between the instruction-side requester (port 0) and the data-side requester (port 1).
- Sits between the CPU memory stages and data_ram.
- Serialises accesses, holds the downstream request stable until the RAM acks, and returns a one-cycle ack plus read data to the granted requester.
- Gives each requester the same cs/ack/stall contract the RAM presents.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width on all ports.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- p0_cs  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0 write enable.
- p0_addr  in  ADDR_WIDTH  port 0 byte address.
- p0_din  in  DATA_WIDTH  port 0 write data.
- p0_dout  out  DATA_WIDTH  port 0 read data; valid while p0_ack=1.
- p0_ack  out  1  port 0 completion pulse, one cycle.
- p0_stall  out  1  p0_cs & ~p0_ack.
- p1_cs, p1_we, p1_addr, p1_din, p1_dout, p1_ack, p1_stall: same as port 0, for port 1.
- mem_cs  out  1  to RAM cs.
- mem_we  out  1  to RAM we.
- mem_addr  out  ADDR_WIDTH  to RAM addr.
- mem_din  out  DATA_WIDTH  to RAM din.
- mem_dout  in  DATA_WIDTH  from RAM dout.
- mem_ack  in  1  from RAM ack.
- arb_state  out  2  current FSM state, for debug.

Behaviour:
- **States:** IDLE=0, BUSY=1, DONE=2. Encoding 3 is illegal and forces IDLE.
- **Reset (rst=1 at a clk edge):**
  - State goes to IDLE; grant=0; last-grant pointer=0.
  - Latched we/addr/din and the dout capture register are cleared to 0.
  - All pX_ack=0, mem_cs=0.
  - Reset mid-BUSY abandons the access. RAM shares rst, so no partial write occurs.
- **IDLE:**
  - If any pX_cs=1, select a winner: fixed priority, port 1 over port 0, unless ARB_ROUND_ROBIN_EN is defined.
  - Register grant and the winner's we/addr/din, then go to BUSY.
  - If no request, stay in IDLE.
- **BUSY:**
  - mem_cs = ~mem_ack (combinational). mem_we/mem_addr/mem_din come from the latched values and are stable for the whole state.
  - Changes on the requester inputs during BUSY are ignored.
  - When mem_ack=1: capture mem_dout, then go to DONE. mem_cs drops in this same cycle so the RAM does not start another access.
- **DONE:**
  - mem_cs=0.
  - p[grant]_ack=1 for exactly this one cycle; p[grant]_dout = captured data.
  - For a write, pX_dout = 0.
  - Next state is IDLE, unconditionally.
- **Non-granted port:** ack=0 and dout=0 at all times.
- **Latency:** the request is sampled in IDLE at cycle N, BUSY starts at N+1, and the requester ack arrives 1 cycle after the cycle with mem_ack=1. A new grant is possible at the earliest 2 cycles after DONE is entered.
- **Simultaneous requests:** exactly one port is granted. The loser keeps its cs high, keeps stall=1, and is served on the next IDLE pass.
- **Back-to-back requests:** a requester may hold cs high straight after its ack; this is treated as a new request in the following IDLE.
- **Spurious mem_ack** outside BUSY is ignored.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant pointer updates when DONE is entered.
  - On simultaneous requests in IDLE, the port other than the last-granted one wins.
  - A single requester always wins.
- Undefined: fixed priority, port 1 always beats port 0; no pointer is instantiated.

Decomposition:
- **Shared package ram_arb_pkg:**
  - State constants S_IDLE, S_BUSY, S_DONE.
  - Port index constants PORT_I=0, PORT_D=1.
  - Default width constants.
- **Sub-module ram_arb_pick:** combinational winner select.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant, valid.
  - Contains the ARB_ROUND_ROBIN_EN variant.
- **Top module:** FSM, latches, and response muxing.

Test Plan:
- **Single read.** Preload RAM word 0x10 = 0xDEADBEEF; p0 reads addr 0x40.
  - Required: mem_cs high through BUSY; p0_ack pulses once with p0_dout=0xDEADBEEF; p1_ack stays 0.
- **Write then read.** p1 writes 0x12345678 to addr 0x80, then reads addr 0x80.
  - Required: write ack with p1_dout=0; read returns 0x12345678; exactly one RAM write.
- **Contention, fixed priority (macro off).** p0 and p1 raise cs in the same cycle.
  - Required: p1 is served first; p0_stall=1 throughout; p0 ack follows after an IDLE gap.
- **Contention, round-robin (macro on).** Both ports hold cs for 4 transactions.
  - Required: grant order is 1,0,1,0.
- **Input stability.** Change p0_addr from 0x40 to 0x44 mid-BUSY.
  - Required: mem_addr stays 0x40; data returned is from 0x40.
- **Reset mid-BUSY.** Assert rst for 1 cycle during a p1 write.
  - Required: next cycle arb_state=0, mem_cs=0, no acks; a subsequent p0 read completes normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants for the two-port data RAM arbiter.
// Holds FSM state codes, port indices and default bus widths.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select for the two requesters.
// ARB_ROUND_ROBIN_EN selects alternating priority on contention.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    assign valid_o = |req_i;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_o = req_i[PORT_D] ? PORT_D : PORT_I;
        // On contention the port served last time yields.
        if (&req_i) begin
            grant_o = ~last_grant_i;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_grant_i;
    assign grant_o     = req_i[PORT_D] ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one multi-cycle RAM port between I-side and D-side.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_cs,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_din,
    output logic [DATA_WIDTH-1:0] p0_dout,
    output logic                  p0_ack,
    output logic                  p0_stall,
    input  logic                  p1_cs,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_din,
    output logic [DATA_WIDTH-1:0] p1_dout,
    output logic                  p1_ack,
    output logic                  p1_stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_ack,
    output logic [1:0]            arb_state
);

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  last_grant;
    logic                  pick_grant;
    logic                  pick_valid;
    logic                  in_busy;
    logic                  in_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_grant = last_q;
`else
    assign last_grant = PORT_I;
`endif

    ram_arb_pick u_pick (
        .req_i        ({p1_cs, p0_cs}),
        .last_grant_i (last_grant),
        .grant_o      (pick_grant),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    we_d    = pick_grant ? p1_we   : p0_we;
                    addr_d  = pick_grant ? p1_addr : p0_addr;
                    din_d   = pick_grant ? p1_din  : p0_din;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    rdata_d = mem_dout;
                    state_d = S_DONE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = grant_q;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= PORT_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= PORT_I;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign in_busy = (state_q == S_BUSY);
    assign in_done = (state_q == S_DONE);

    // Drop cs in the ack cycle so the RAM does not start a second access.
    assign mem_cs   = in_busy & ~mem_ack;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

    assign rsp_data = we_q ? '0 : rdata_q;

    assign p0_ack   = in_done & (grant_q == PORT_I);
    assign p1_ack   = in_done & (grant_q == PORT_D);
    assign p0_dout  = p0_ack ? rsp_data : '0;
    assign p1_dout  = p1_ack ? rsp_data : '0;
    assign p0_stall = p0_cs & ~p0_ack;
    assign p1_stall = p1_cs & ~p1_ack;

    assign arb_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed checks of ram_arbiter against a
// transaction-level reference model and a behavioural multi-cycle RAM.
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cs  = 2'b00;
    logic [1:0]    we  = 2'b00;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];
    logic [DW-1:0] dout [2];
    logic [DW-1:0] p0_dout, p1_dout;
    logic          p0_ack, p1_ack, p0_stall, p1_stall;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_ack;
    logic [1:0]    arb_state;
    logic          ram_ack = 1'b0;
    logic          spur = 1'b0;
    wire  [1:0]    ack   = {p1_ack, p0_ack};
    wire  [1:0]    stall = {p1_stall, p0_stall};

    assign mem_ack = ram_ack | spur;
    assign dout[0] = p0_dout;
    assign dout[1] = p1_dout;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_cs(cs[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_din(din[0]),
        .p0_dout(p0_dout), .p0_ack(p0_ack), .p0_stall(p0_stall),
        .p1_cs(cs[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_din(din[1]),
        .p1_dout(p1_dout), .p1_ack(p1_ack), .p1_stall(p1_stall),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    // Arbitration rule at transaction level.
    function automatic int winner(input logic [1:0] req, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        if (req == 2'b11) return 1 - last;
`endif
        return req[1] ? 1 : 0;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multi-cycle RAM, 64 words.
    logic [DW-1:0] ram [64];
    bit ram_loaded = 1'b0;
    int lat_cfg = 1;
    int rnd_lat = 0;
    int cnt = 0;
    int wcnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            ram_ack <= 1'b0;
            cnt     <= 0;
            mem_dout <= '0;
            if (!ram_loaded) begin
                for (int i = 0; i < 64; i++) ram[i] <= pat(i);
                ram_loaded <= 1'b1;
            end
        end else if (ram_ack) begin
            ram_ack <= 1'b0;
            cnt     <= 0;
        end else if (mem_cs) begin
            if (cnt >= (lat_cfg < 0 ? rnd_lat : lat_cfg)) begin
                ram_ack  <= 1'b1;
                mem_dout <= ram[mem_addr[7:2]];
                if (mem_we) begin
                    ram[mem_addr[7:2]] <= mem_din;
                    wcnt <= wcnt + 1;
                end
                rnd_lat <= $urandom_range(0, 3);
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [64];
    int last_served = 0;
    int exp_grant = 0;
    int mack_cyc = -10;
    int order_q [$];
    logic [1:0]    prev_st = ST_IDLE;
    logic [1:0]    prev_ack = 2'b00;
    logic [AW-1:0] busy_addr = '0;
    logic          busy_we = 1'b0;
    logic [DW-1:0] busy_din = '0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_st  = ST_IDLE;
            prev_ack = 2'b00;
        end else begin
            chk("ack_excl", 32'(p0_ack & p1_ack), 0);
            chk("ack_pulse", 32'(ack & prev_ack), 0);
            if (!p0_ack) chk("p0_dout_quiet", p0_dout, 0);
            if (!p1_ack) chk("p1_dout_quiet", p1_dout, 0);
            chk("mem_cs", 32'(mem_cs),
                32'(arb_state == ST_BUSY && !mem_ack));
            if (arb_state == ST_BUSY && prev_st == ST_IDLE) begin
                exp_grant = winner(cs, last_served);
                busy_addr = addr[exp_grant];
                busy_we   = we[exp_grant];
                busy_din  = din[exp_grant];
            end
            if (arb_state == ST_BUSY) begin
                chk("mem_addr", mem_addr, busy_addr);
                chk("mem_we", 32'(mem_we), 32'(busy_we));
                if (busy_we) chk("mem_din", mem_din, busy_din);
                if (mem_ack) mack_cyc = cyc;
            end
            prev_st  = arb_state;
            prev_ack = ack;
        end
    end

    task automatic txn(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit hold,
                       output logic [DW-1:0] rdata);
        int n = 0;
        logic [DW-1:0] want;
        rdata = '0;
        @(negedge clk);
        cs[p] = 1'b1;
        we[p] = w;
        addr[p] = a;
        din[p] = d;
        forever begin
            @(posedge clk);
            #1;
            if (ack[p]) break;
            chk(p == 1 ? "p1_stall" : "p0_stall", 32'(stall[p]), 1);
            n++;
            if (n > 100) begin
                chk("ack_timeout", n, 0);
                cs[p] = 1'b0;
                return;
            end
        end
        want = w ? '0 : ref_mem[a[7:2]];
        rdata = dout[p];
        chk(p == 1 ? "p1_dout" : "p0_dout", dout[p], want);
        chk("ack_latency", cyc - mack_cyc, 1);
        chk("grant", p, exp_grant);
        chk("stall_at_ack", 32'(stall[p]), 0);
        if (w) ref_mem[a[7:2]] = d;
        last_served = p;
        order_q.push_back(p);
        if (!hold) begin
            @(negedge clk);
            cs[p] = 1'b0;
        end
    endtask

    task automatic wait_state(input logic [1:0] s);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (arb_state !== s && n < 40);
        chk("wait_state", 32'(arb_state), 32'(s));
    endtask

    logic [DW-1:0] rd, rd0, rd1;
    int exp_order [$];
    int rem [2];
    int lst;
    int w0;
    int n;

    initial begin
        addr[0] = '0; addr[1] = '0;
        din[0]  = '0; din[1]  = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(arb_state), 0);
        chk("rst_mem_cs", 32'(mem_cs), 0);
        chk("rst_acks", 32'(ack), 0);
        chk("rst_p0_dout", p0_dout, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        rst = 1'b0;

        lat_cfg = 2;
        order_q.delete();
        txn(0, 1'b0, 32'h40, '0, 1'b0, rd);
        chk("single_rd", rd, 32'hDEADBEEF);
        chk("single_n_acks", order_q.size(), 1);

        // Both ports hold cs for two back-to-back accesses each.
        order_q.delete();
        exp_order.delete();
        rem[0] = 2; rem[1] = 2; lst = last_served;
        for (int k = 0; k < 4; k++) begin
            int wv;
            wv = winner({1'(rem[1] > 0), 1'(rem[0] > 0)}, lst);
            exp_order.push_back(wv);
            rem[wv]--;
            lst = wv;
        end
        fork
            begin
                txn(0, 1'b0, 32'h04, '0, 1'b1, rd0);
                txn(0, 1'b1, 32'h08, 32'hCAFE0001, 1'b0, rd0);
            end
            begin
                txn(1, 1'b0, 32'h0C, '0, 1'b1, rd1);
                txn(1, 1'b1, 32'h10, 32'hCAFE0002, 1'b0, rd1);
            end
        join
        chk("contend_n", order_q.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < order_q.size()) chk("contend_order", order_q[k], exp_order[k]);

        w0 = wcnt;
        txn(1, 1'b1, 32'h80, 32'h12345678, 1'b0, rd);
        chk("wr_dout_zero", rd, 0);
        txn(1, 1'b0, 32'h80, '0, 1'b0, rd);
        chk("rd_back", rd, 32'h12345678);
        chk("wr_count", wcnt - w0, 1);

        lat_cfg = 4;
        @(negedge clk);
        cs[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40; din[0] = '0;
        wait_state(ST_BUSY);
        @(negedge clk);
        addr[0] = 32'h44;
        @(posedge clk);
        #1;
        chk("stable_addr", mem_addr, 32'h40);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!p0_ack && n < 40);
        chk("stable_ack", 32'(p0_ack), 1);
        chk("stable_data", p0_dout, ref_mem[16]);
        last_served = 0;
        @(negedge clk);
        cs[0] = 1'b0;

        repeat (2) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(posedge clk);
        #1;
        chk("spur_state", 32'(arb_state), 0);
        chk("spur_acks", 32'(ack), 0);

        lat_cfg = 6;
        w0 = wcnt;
        @(negedge clk);
        cs[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h88; din[1] = 32'hBAD0BAD0;
        wait_state(ST_BUSY);
        @(negedge clk);
        rst = 1'b1;
        cs[1] = 1'b0;
        we[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("rstbusy_state", 32'(arb_state), 0);
        chk("rstbusy_mem_cs", 32'(mem_cs), 0);
        chk("rstbusy_acks", 32'(ack), 0);
        @(negedge clk);
        rst = 1'b0;
        last_served = 0;
        chk("rstbusy_no_write", wcnt - w0, 0);
        lat_cfg = 1;
        txn(0, 1'b0, 32'h88, '0, 1'b0, rd);
        chk("post_rst_rd", rd, pat(34));

        lat_cfg = -1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    bit h;
                    h = (i < 24) && ($urandom_range(0, 1) == 1);
                    txn(0, 1'($urandom_range(0, 1)),
                        {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                        $urandom(), h, rd0);
                    if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    bit h;
                    h = (i < 24) && ($urandom_range(0, 1) == 1);
                    txn(1, 1'($urandom_range(0, 1)),
                        {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                        $urandom(), h, rd1);
                    if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
